// File: rtl/reg_file_param_pkg.sv
// Shared definitions for the parametrised register file.
//
// Holds the default geometry (word width, depth, address width), the default
// register-zero behaviour and the default reset value, so every block that
// instantiates the register file agrees on them. Also provides a small
// address range helper used by the read bypass logic.
package reg_file_param_pkg;

    localparam int unsigned DEF_WIDTH     = 32;
    localparam int unsigned DEF_DEPTH     = 32;
    localparam int unsigned DEF_ADDR_W    = 5;
    localparam int unsigned DEF_ZERO_R0   = 1;

    // Wide enough for any sensible WIDTH; the top casts it to WIDTH bits.
    localparam logic [63:0] DEF_RESET_VAL = 64'h0;

    // True when addr names a physically present register.
    function automatic logic addr_in_range(input int unsigned addr,
                                           input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Write-enable decoder for the register file.
//
// Turns a binary address into a one-hot vector with 2^ADDR_W lanes. All lanes
// are low unless en is high, so the output can drive per-word load enables
// directly.
//
// Ports
//   addr   : in  [ADDR_W-1:0]     binary address
//   en     : in  1                gate; low forces every lane low
//   onehot : out [2^ADDR_W-1:0]   one-hot enable vector
module decoder_onehot #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic [ADDR_W-1:0]       addr,
    input  logic                    en,
    output logic [(1<<ADDR_W)-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: one write port, two registered read ports.
//
// Storage is one load-enabled register per word, enabled by a one-hot
// decode of the write address. Reads are registered (one-cycle latency)
// and qualified by RVALID. A read of the address being written on the same
// edge returns the incoming write data. Addresses at or above DEPTH read as
// zero and swallow writes; with ZERO_R0 set, register 0 behaves the same way.
//
// The write-address port owns the name ADDR_W, so the address-width
// parameter is called ADDR_WIDTH.
//
// Parameters
//   WIDTH      : bits per word
//   DEPTH      : number of registers (2..1024)
//   ADDR_WIDTH : address bits, 2^ADDR_WIDTH >= DEPTH
//   ZERO_R0    : 1 = register 0 is hard-wired to zero
//   RESET_VAL  : value loaded into every register on reset
//
// Ports
//   CLK     : in  1           clock, rising edge
//   RESET   : in  1           asynchronous reset, active low
//   READ    : in  1           read request (both ports)
//   WRITE   : in  1           write request
//   ADDR_R1 : in  ADDR_WIDTH  read address, port 1
//   ADDR_R2 : in  ADDR_WIDTH  read address, port 2
//   ADDR_W  : in  ADDR_WIDTH  write address
//   DATA_W  : in  WIDTH       write data
//   DATA_R1 : out WIDTH       registered read data, port 1
//   DATA_R2 : out WIDTH       registered read data, port 2
//   RVALID  : out 1           one cycle high after each accepted read
module reg_file_param
    import reg_file_param_pkg::*;
#(
    parameter int unsigned      WIDTH      = DEF_WIDTH,
    parameter int unsigned      DEPTH      = DEF_DEPTH,
    parameter int unsigned      ADDR_WIDTH = DEF_ADDR_W,
    parameter int unsigned      ZERO_R0    = DEF_ZERO_R0,
    parameter logic [WIDTH-1:0] RESET_VAL  = WIDTH'(DEF_RESET_VAL)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [WIDTH-1:0]      DATA_W,
    output logic [WIDTH-1:0]      DATA_R1,
    output logic [WIDTH-1:0]      DATA_R2,
    output logic                  RVALID
);

    localparam int unsigned NWORDS = 1 << ADDR_WIDTH;

    logic [NWORDS-1:0] we_onehot;
    logic [WIDTH-1:0]  words [NWORDS];
    logic              wr_addr_live;
    logic              bypass_r1;
    logic              bypass_r2;
    logic [WIDTH-1:0]  rd_r1;
    logic [WIDTH-1:0]  rd_r2;

    decoder_onehot #(
        .ADDR_W (ADDR_WIDTH)
    ) u_decoder_onehot (
        .addr   (ADDR_W),
        .en     (WRITE),
        .onehot (we_onehot)
    );

    // The address space is padded out to a full power of two so the read
    // mux can index it directly; absent and hard-zero words are constants
    // and their write enables are simply dropped.
    for (genvar i = 0; i < NWORDS; i++) begin : g_word
        if ((i >= DEPTH) || ((i == 0) && (ZERO_R0 != 0))) begin : g_const
            logic unused_we;
            assign unused_we = we_onehot[i];
            assign words[i]  = '0;
        end else begin : g_reg
            logic [WIDTH-1:0] q;
            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET) begin
                    q <= RESET_VAL;
                end else if (we_onehot[i]) begin
                    q <= DATA_W;
                end
            end
            assign words[i] = q;
        end
    end

    // A same-edge write only forwards when it would actually land in a
    // real, writable register; otherwise the read sees the stored constant.
    always_comb begin
        wr_addr_live = WRITE
                     && addr_in_range(32'(ADDR_W), DEPTH)
                     && !((ZERO_R0 != 0) && (ADDR_W == '0));
        bypass_r1    = wr_addr_live && (ADDR_R1 == ADDR_W);
        bypass_r2    = wr_addr_live && (ADDR_R2 == ADDR_W);
        rd_r1        = bypass_r1 ? DATA_W : words[ADDR_R1];
        rd_r2        = bypass_r2 ? DATA_W : words[ADDR_R2];
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            DATA_R1 <= '0;
            DATA_R2 <= '0;
            RVALID  <= 1'b0;
        end else begin
            RVALID <= READ;
            if (READ) begin
                DATA_R1 <= rd_r1;
                DATA_R2 <= rd_r2;
            end
        end
    end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the bits per register word.
REQ-002 The block SHALL have parameter DEPTH, default 32, giving the number of registers (2..1024).
REQ-003 The block SHALL have parameter ADDR_W, default 5, giving the address width, with 2^ADDR_W >= DEPTH.
REQ-004 The block SHALL have parameter ZERO_R0, default 1; when 1, register 0 reads 0 and ignores writes.
REQ-005 The block SHALL have parameter RESET_VAL, default 0, giving the WIDTH-bit value every register takes on reset.
REQ-006 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port RESET, input, 1 bit: asynchronous, active-low reset (RESET=0 resets).
REQ-008 The block SHALL have port READ, input, 1 bit: read request for both read ports.
REQ-009 The block SHALL have port WRITE, input, 1 bit: write request.
REQ-010 The block SHALL have port ADDR_R1, input, ADDR_W bits: read port 1 address.
REQ-011 The block SHALL have port ADDR_R2, input, ADDR_W bits: read port 2 address.
REQ-012 The block SHALL have port ADDR_W, input, ADDR_W bits: write address.
REQ-013 The block SHALL have port DATA_W, input, WIDTH bits: write data.
REQ-014 The block SHALL have port DATA_R1, output, WIDTH bits: registered read data, port 1.
REQ-015 The block SHALL have port DATA_R2, output, WIDTH bits: registered read data, port 2.
REQ-016 The block SHALL have port RVALID, output, 1 bit: high for exactly one cycle after each accepted read.

Function
REQ-017 With WRITE=1 at a rising CLK edge, the block SHALL store DATA_W into register ADDR_W, visible to reads from the next edge onward.
REQ-018 With READ=1 at a rising CLK edge, the block SHALL load DATA_R1/DATA_R2 from ADDR_R1/ADDR_R2 and set RVALID=1, giving one-cycle latency.
REQ-019 With READ=0, DATA_R1/DATA_R2 SHALL hold their last values and RVALID SHALL be 0.
REQ-020 When READ=1 and WRITE=1 occur on the same edge and a read address equals ADDR_W, that read port SHALL return DATA_W (write-through bypass).
REQ-021 Bypass SHALL NOT apply to register 0 when ZERO_R0=1; that port returns 0.
REQ-022 A write to an address >= DEPTH SHALL be ignored; a read of an address >= DEPTH SHALL return 0 with RVALID=1.
REQ-023 Both read ports SHALL be independent; ADDR_R1 = ADDR_R2 SHALL return identical data on both ports.
REQ-024 Back-to-back reads SHALL be supported every cycle, with RVALID staying high continuously.
REQ-025 Writes on consecutive edges to the same address SHALL leave the last value.

Reset
REQ-026 RESET=0 SHALL immediately, independent of CLK, set every register to RESET_VAL (register 0 to 0 if ZERO_R0=1), DATA_R1=0, DATA_R2=0 and RVALID=0.
REQ-027 A read or write coinciding with RESET=0 SHALL be discarded.
REQ-028 The first edge after RESET returns to 1 SHALL operate normally.

Structure
REQ-029 Default WIDTH/DEPTH/ADDR_W values and the RESET_VAL default SHALL live in the shared common-definitions include, not in this module.
REQ-030 Write enables SHALL be produced by one sub-module, decoder_onehot (parametrised ADDR_W -> 2^ADDR_W one-hot, gated by WRITE); storage SHALL use per-word load-enabled registers.

Verification
REQ-031 The bench SHALL cover reset with defaults: RESET=0 then a READ of addresses 5 and 31 -> DATA_R1=0, DATA_R2=0, RVALID=1 one cycle after READ.
REQ-032 The bench SHALL cover write then read: write 32'hDEADBEEF to 7, next cycle READ R1=7, R2=0 -> DATA_R1=DEADBEEF, DATA_R2=0.
REQ-033 The bench SHALL cover bypass: same edge WRITE 3<=32'h12345678 and READ R1=3 -> DATA_R1=12345678 next cycle.
REQ-034 The bench SHALL cover register-zero protection: write 32'hFFFFFFFF to 0, then read 0 -> 0; repeat with ZERO_R0=0 -> FFFFFFFF.
REQ-035 The bench SHALL cover a non-power-of-two depth: DEPTH=20, write 32'hA5 to 25, then read 25 -> 0 and registers 0..19 unchanged.
REQ-036 The bench SHALL cover mid-operation reset: write 32'h55 to 9, assert RESET=0 between edges -> outputs clear at once and a later read of 9 returns RESET_VAL.
